// File: rtl/bypass_scoreboard.sv
// N-lane forwarding/hazard unit in ID: tracks in-flight writers per stage and lane,
// resolves operand bypass selects, load-use stalls and intra-bundle split requests.
// Optional: define BYPASS_STATS_EN to add saturating stat_fwd / stat_stall counters.
module bypass_scoreboard #(
  parameter int LANES            = 2,
  parameter int STAGES           = 3,
  parameter int REG_W            = 5,
  parameter int LOAD_READY_STAGE = 1,
  localparam int SW              = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int LW              = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int SEL_W           = 1 + SW + LW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         issue_valid,
  input  logic [LANES-1:0]         issue_we,
  input  logic [LANES-1:0]         issue_load,
  input  logic [LANES*REG_W-1:0]   issue_rd,
  input  logic [LANES*REG_W-1:0]   src_rs,
  input  logic [LANES*REG_W-1:0]   src_rt,
  input  logic                     freeze,
  input  logic                     flush_ex,
  output logic [LANES*SEL_W-1:0]   fwd_sel_rs,
  output logic [LANES*SEL_W-1:0]   fwd_sel_rt,
  output logic [STAGES*LANES-1:0]  bp_use,
  output logic                     load_use_stall,
  output logic [LANES-1:0]         split_req
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]              stat_fwd,
  output logic [31:0]              stat_stall
`endif
);

  logic [STAGES-1:0][LANES-1:0]            tag_vld;
  logic [STAGES-1:0][LANES-1:0]            tag_ld;
  logic [STAGES-1:0][LANES-1:0][REG_W-1:0] tag_rd;

  logic [SEL_W:0] rs_res [LANES];
  logic [SEL_W:0] rt_res [LANES];
  logic           stall_raw;
  logic           bubble;

  // Winning writer for one operand: {is_early_load, select}. Later assignments win,
  // so the scan runs oldest stage first and lowest lane first.
  function automatic logic [SEL_W:0] resolve(input logic [REG_W-1:0] x);
    logic [SEL_W-1:0] sel;
    logic             hazard;
    sel    = '0;
    hazard = 1'b0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (tag_vld[s][l] && (tag_rd[s][l] == x) && (x != '0)) begin
          sel    = {1'b1, SW'(s), LW'(l)};
          hazard = tag_ld[s][l] && (s < LOAD_READY_STAGE);
        end
      end
    end
    return {hazard, sel};
  endfunction

  assign load_use_stall = stall_raw & ~rst & ~freeze;
  assign bubble         = load_use_stall | flush_ex;

  // ID stage: combinational resolve against the registered tags
  always_comb begin
    stall_raw  = 1'b0;
    bp_use     = '0;
    fwd_sel_rs = '0;
    fwd_sel_rt = '0;
    split_req  = '0;
    for (int j = 0; j < LANES; j++) begin
      rs_res[j] = resolve(src_rs[j*REG_W +: REG_W]);
      rt_res[j] = resolve(src_rt[j*REG_W +: REG_W]);
      fwd_sel_rs[j*SEL_W +: SEL_W] = rs_res[j][SEL_W-1:0];
      fwd_sel_rt[j*SEL_W +: SEL_W] = rt_res[j][SEL_W-1:0];
      stall_raw = stall_raw | rs_res[j][SEL_W] | rt_res[j][SEL_W];
    end
    for (int s = 0; s < STAGES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        for (int j = 0; j < LANES; j++) begin
          if ((rs_res[j][SEL_W-1:0] == {1'b1, SW'(s), LW'(l)}) ||
              (rt_res[j][SEL_W-1:0] == {1'b1, SW'(s), LW'(l)}))
            bp_use[s*LANES + l] = 1'b1;
        end
      end
    end
    // Same-bundle RAW cannot be forwarded; the younger lane must be split off.
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (issue_valid[i] && issue_we[i] && (issue_rd[i*REG_W +: REG_W] != '0) &&
            ((issue_rd[i*REG_W +: REG_W] == src_rs[j*REG_W +: REG_W]) ||
             (issue_rd[i*REG_W +: REG_W] == src_rt[j*REG_W +: REG_W])))
          split_req[j] = 1'b1;
      end
    end
  end

  // Stage boundary ID -> ID/EX -> EX/MEM -> MEM/WB: valid bits (control)
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else if (!freeze) begin
      for (int s = 1; s < STAGES; s++)
        tag_vld[s] <= tag_vld[s-1];
      for (int l = 0; l < LANES; l++)
        tag_vld[0][l] <= !bubble && issue_valid[l] && issue_we[l] &&
                         (issue_rd[l*REG_W +: REG_W] != '0);
    end
  end

  // Stage boundary ID -> ID/EX -> EX/MEM -> MEM/WB: tag payload (data, no reset)
  always_ff @(posedge clk) begin
    if (!freeze) begin
      for (int s = 1; s < STAGES; s++) begin
        tag_rd[s] <= tag_rd[s-1];
        tag_ld[s] <= tag_ld[s-1];
      end
      for (int l = 0; l < LANES; l++) begin
        tag_rd[0][l] <= issue_rd[l*REG_W +: REG_W];
        tag_ld[0][l] <= issue_load[l];
      end
    end
  end

`ifdef BYPASS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else if (!freeze) begin
      if ((bp_use != '0) && (stat_fwd != 32'hFFFF_FFFF))
        stat_fwd <= stat_fwd + 32'd1;
      if (load_use_stall && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard (LANES=2, STAGES=3, LOAD_READY_STAGE=1, SEL_W=4).
module tb_bypass_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  issue_valid, issue_we, issue_load;
  logic [9:0]  issue_rd, src_rs, src_rt;
  logic        freeze, flush_ex;
  logic [7:0]  fwd_sel_rs, fwd_sel_rt;
  logic [5:0]  bp_use;
  logic        load_use_stall;
  logic [1:0]  split_req;
`ifdef BYPASS_STATS_EN
  logic [31:0] stat_fwd, stat_stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bypass_scoreboard #(.LANES(2), .STAGES(3), .REG_W(5), .LOAD_READY_STAGE(1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_load(issue_load),
    .issue_rd(issue_rd), .src_rs(src_rs), .src_rt(src_rt),
    .freeze(freeze), .flush_ex(flush_ex),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .bp_use(bp_use),
    .load_use_stall(load_use_stall), .split_req(split_req)
`ifdef BYPASS_STATS_EN
    , .stat_fwd(stat_fwd), .stat_stall(stat_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = '0; issue_we = '0; issue_load = '0; issue_rd = '0;
    src_rs = '0; src_rt = '0; freeze = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic issue(input int l, input logic ld, input logic [4:0] rd);
    issue_valid[l] = 1'b1;
    issue_we[l]    = 1'b1;
    issue_load[l]  = ld;
    issue_rd[l*5 +: 5] = rd;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      issue_valid = 2'($urandom); issue_we = 2'($urandom); issue_load = 2'($urandom);
      issue_rd = 10'($urandom); src_rs = 10'($urandom); src_rt = 10'($urandom);
      freeze = 1'b0; flush_ex = 1'b0;
      step();
      tests++;
      if ({fwd_sel_rs, fwd_sel_rt} !== 16'h0) begin
        fails++; $display("FAIL reset_sel: got %h, expected 0000", {fwd_sel_rs, fwd_sel_rt});
      end
      tests++;
      if (bp_use !== 6'b0) begin
        fails++; $display("FAIL reset_bp_use: got %b, expected 000000", bp_use);
      end
      tests++;
      if (load_use_stall !== 1'b0) begin
        fails++; $display("FAIL reset_stall: got %b, expected 0", load_use_stall);
      end
    end
    idle();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fwd_alu();
    do_reset();
    issue(0, 1'b0, 5'd5);
    step();
    idle();
    src_rs[9:5] = 5'd5;
    #1;
    tests++;
    if ({fwd_sel_rs[7:4], bp_use} !== {4'b1000, 6'b000001}) begin
      fails++; $display("FAIL fwd_s0: got sel=%b bp=%b, expected sel=1000 bp=000001", fwd_sel_rs[7:4], bp_use);
    end
    step();
    tests++;
    if ({fwd_sel_rs[7:4], bp_use} !== {4'b1010, 6'b000100}) begin
      fails++; $display("FAIL fwd_s1: got sel=%b bp=%b, expected sel=1010 bp=000100", fwd_sel_rs[7:4], bp_use);
    end
    step();
    tests++;
    if ({fwd_sel_rs[7:4], bp_use} !== {4'b1100, 6'b010000}) begin
      fails++; $display("FAIL fwd_s2: got sel=%b bp=%b, expected sel=1100 bp=010000", fwd_sel_rs[7:4], bp_use);
    end
    step();
    tests++;
    if ({fwd_sel_rs[7:4], bp_use} !== {4'b0000, 6'b000000}) begin
      fails++; $display("FAIL fwd_drop: got sel=%b bp=%b, expected sel=0000 bp=000000", fwd_sel_rs[7:4], bp_use);
    end
  endtask

  task automatic test_priority();
    do_reset();
    issue(0, 1'b0, 5'd7);
    step();
    idle();
    issue(1, 1'b0, 5'd7);
    step();
    idle();
    src_rt[4:0] = 5'd7;
    #1;
    tests++;
    if ({fwd_sel_rt[3:0], bp_use} !== {4'b1001, 6'b000010}) begin
      fails++; $display("FAIL prio_youngest: got sel=%b bp=%b, expected sel=1001 bp=000010", fwd_sel_rt[3:0], bp_use);
    end
    do_reset();
    issue(0, 1'b0, 5'd8);
    issue(1, 1'b0, 5'd8);
    step();
    idle();
    src_rs[4:0] = 5'd8;
    #1;
    tests++;
    if (fwd_sel_rs[3:0] !== 4'b1001) begin
      fails++; $display("FAIL prio_lane: got %b, expected 1001", fwd_sel_rs[3:0]);
    end
    do_reset();
    issue(0, 1'b0, 5'd0);
    step();
    idle();
    src_rs[4:0] = 5'd0;
    #1;
    tests++;
    if ({fwd_sel_rs[3:0], bp_use} !== {4'b0000, 6'b000000}) begin
      fails++; $display("FAIL prio_r0: got sel=%b bp=%b, expected sel=0000 bp=000000", fwd_sel_rs[3:0], bp_use);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(0, 1'b1, 5'd3);
    step();
    idle();
    src_rs[4:0] = 5'd3;
    issue(1, 1'b0, 5'd6);
    #1;
    tests++;
    if ({load_use_stall, fwd_sel_rs[3:0]} !== {1'b1, 4'b1000}) begin
      fails++; $display("FAIL lu_stall: got stall=%b sel=%b, expected stall=1 sel=1000", load_use_stall, fwd_sel_rs[3:0]);
    end
    step();
    issue_valid = '0; issue_we = '0; issue_rd = '0;
    src_rt[9:5] = 5'd6;
    #1;
    tests++;
    if ({load_use_stall, fwd_sel_rs[3:0]} !== {1'b0, 4'b1010}) begin
      fails++; $display("FAIL lu_release: got stall=%b sel=%b, expected stall=0 sel=1010", load_use_stall, fwd_sel_rs[3:0]);
    end
    tests++;
    if (fwd_sel_rt[7:4] !== 4'b0000) begin
      fails++; $display("FAIL lu_bubble: got %b, expected 0000", fwd_sel_rt[7:4]);
    end
    step();
    tests++;
    if ({load_use_stall, fwd_sel_rs[3:0]} !== {1'b0, 4'b1100}) begin
      fails++; $display("FAIL lu_s2: got stall=%b sel=%b, expected stall=0 sel=1100", load_use_stall, fwd_sel_rs[3:0]);
    end
`ifdef BYPASS_STATS_EN
    tests++;
    if (stat_stall !== 32'd1) begin
      fails++; $display("FAIL stat_stall: got %0d, expected 1", stat_stall);
    end
`endif
  endtask

  task automatic test_freeze();
    do_reset();
    issue(1, 1'b0, 5'd9);
    step();
    idle();
    freeze = 1'b1;
    src_rs[4:0] = 5'd9;
    #1;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (fwd_sel_rs[3:0] !== 4'b1001) begin
        fails++; $display("FAIL frz_hold%0d: got %b, expected 1001", c, fwd_sel_rs[3:0]);
      end
      if (c < 3) step();
    end
    freeze = 1'b0;
    step();
    tests++;
    if (fwd_sel_rs[3:0] !== 4'b1011) begin
      fails++; $display("FAIL frz_resume: got %b, expected 1011", fwd_sel_rs[3:0]);
    end
    do_reset();
    issue(0, 1'b1, 5'd2);
    step();
    idle();
    src_rs[4:0] = 5'd2;
    freeze = 1'b1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL frz_stall_mask: got %b, expected 0", load_use_stall);
    end
    freeze = 1'b0;
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin
      fails++; $display("FAIL frz_stall_unmask: got %b, expected 1", load_use_stall);
    end
    do_reset();
    issue(0, 1'b0, 5'd11);
    flush_ex = 1'b1;
    step();
    idle();
    src_rs[4:0] = 5'd11;
    #1;
    tests++;
    if ({fwd_sel_rs[3:0], bp_use} !== {4'b0000, 6'b000000}) begin
      fails++; $display("FAIL flush: got sel=%b bp=%b, expected sel=0000 bp=000000", fwd_sel_rs[3:0], bp_use);
    end
  endtask

  task automatic test_split();
    do_reset();
    issue(0, 1'b0, 5'd4);
    src_rs[9:5] = 5'd4;
    #1;
    tests++;
    if (split_req !== 2'b10) begin
      fails++; $display("FAIL split_rs: got %b, expected 10", split_req);
    end
    idle();
    issue(1, 1'b0, 5'd4);
    src_rt[4:0] = 5'd4;
    #1;
    tests++;
    if (split_req !== 2'b00) begin
      fails++; $display("FAIL split_older: got %b, expected 00", split_req);
    end
    idle();
    issue(0, 1'b0, 5'd12);
    issue_we[0] = 1'b0;
    src_rt[9:5] = 5'd12;
    #1;
    tests++;
    if (split_req !== 2'b00) begin
      fails++; $display("FAIL split_no_we: got %b, expected 00", split_req);
    end
    idle();
    issue(0, 1'b0, 5'd13);
    src_rt[9:5] = 5'd13;
    #1;
    tests++;
    if (split_req !== 2'b10) begin
      fails++; $display("FAIL split_rt: got %b, expected 10", split_req);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(0, 1'b1, 5'd3);
    step();
    idle();
    src_rs[4:0] = 5'd3;
    rst = 1'b1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++; $display("FAIL rst_stall_mask: got %b, expected 0", load_use_stall);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if ({fwd_sel_rs[3:0], bp_use, load_use_stall} !== 11'b0) begin
      fails++; $display("FAIL rst_discard: got sel=%b bp=%b stall=%b, expected all 0", fwd_sel_rs[3:0], bp_use, load_use_stall);
    end
    step();
    tests++;
    if ({fwd_sel_rs[3:0], bp_use} !== 10'b0) begin
      fails++; $display("FAIL rst_no_stale: got sel=%b bp=%b, expected 0", fwd_sel_rs[3:0], bp_use);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fwd_alu();
    test_priority();
    test_load_use();
    test_freeze();
    test_split();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
